// File: rtl/pipeline_stall_sequencer_if.sv
// pipeline_stall_sequencer_if: hazard flags in, pipeline-register enables/flushes and status out
interface pipeline_stall_sequencer_if #(parameter int CNT_W = 16);
  logic load_use_hazard, branch_taken, jump, mem_req, mem_ready, halt;
  logic PC_Write, IFID_Write, IFID_flush, IDEX_flush, pipe_freeze, mem_timeout_err;
  logic [2:0] state;
  logic [CNT_W-1:0] stall_count;
  modport master(
    output load_use_hazard, branch_taken, jump, mem_req, mem_ready, halt,
    input PC_Write, IFID_Write, IFID_flush, IDEX_flush, pipe_freeze, mem_timeout_err, state, stall_count
  );
  modport slave(
    input load_use_hazard, branch_taken, jump, mem_req, mem_ready, halt,
    output PC_Write, IFID_Write, IFID_flush, IDEX_flush, pipe_freeze, mem_timeout_err, state, stall_count
  );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: turns hazard flags into same-cycle pipeline enables/flushes for the 5-stage core
module pipeline_stall_sequencer #(
  parameter int LOAD_STALL  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  pipeline_stall_sequencer_if.slave bus
);
  typedef enum logic [2:0] {RUN = 3'd0, LU_STALL = 3'd1, MEM_WAIT = 3'd2, HALTED = 3'd3, ERR = 3'd4} state_t;
  state_t state_q, state_d, ret_q, ret_d;
  logic [3:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic pcw, ifw, ifl, idf, frz, mem_stall;
  assign mem_stall = bus.mem_req && !bus.mem_ready;
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    lu_cnt_d = lu_cnt_q;
    timer_d = timer_q;
    err_d = err_q;
    pcw = 1'b1;
    ifw = 1'b1;
    ifl = 1'b0;
    idf = 1'b0;
    frz = 1'b0;
    unique case (state_q)
      RUN:
        if (mem_stall) begin
          {pcw, ifw, frz} = 3'b001;
          ret_d = RUN;
          timer_d = 8'd1;
          state_d = MEM_WAIT;
        end else if (bus.branch_taken) begin
          {ifl, idf} = 2'b11;
        end else if (bus.load_use_hazard) begin
          {pcw, ifw, idf} = 3'b001;
          if (LOAD_STALL > 1) begin
            lu_cnt_d = 4'(LOAD_STALL - 1);
            state_d = LU_STALL;
          end
        end else if (bus.jump) begin
          ifl = 1'b1;
        end else if (bus.halt) begin
          {pcw, ifw, idf} = 3'b001;
          state_d = HALTED;
        end
      LU_STALL:
        if (mem_stall) begin
          {pcw, ifw, frz} = 3'b001;
          ret_d = LU_STALL;
          timer_d = 8'd1;
          state_d = MEM_WAIT;
        end else begin
          {pcw, ifw, idf} = 3'b001;
          lu_cnt_d = lu_cnt_q - 4'd1;
          state_d = lu_cnt_q == 4'd1 ? RUN : LU_STALL;
        end
      MEM_WAIT:
        if (timer_q == 8'(MEM_TIMEOUT)) begin
          {pcw, ifw, frz} = 3'b001;
          err_d = 1'b1;
          state_d = ERR;
        end else if (!bus.mem_ready) begin
          {pcw, ifw, frz} = 3'b001;
          timer_d = timer_q + {7'd0, timer_q != 8'hff};
        end else begin
          // release cycle replays the return state's pattern without re-evaluating hazards
          {pcw, ifw, idf} = ret_q == LU_STALL ? 3'b001 : 3'b110;
          state_d = ret_q;
        end
      HALTED: {pcw, ifw, idf} = 3'b001;
      ERR: {pcw, ifw, frz} = 3'b001;
      default: state_d = RUN;
    endcase
    cnt_d = (!pcw && state_q inside {RUN, LU_STALL, MEM_WAIT} && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q <= RUN;
      lu_cnt_q <= '0;
      timer_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      lu_cnt_q <= lu_cnt_d;
      timer_q <= timer_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.PC_Write = pcw && !reset;
  assign bus.IFID_Write = ifw && !reset;
  assign bus.IFID_flush = ifl || reset;
  assign bus.IDEX_flush = idf || reset;
  assign bus.pipe_freeze = frz && !reset;
  assign bus.state = state_q;
  assign bus.stall_count = cnt_q;
  assign bus.mem_timeout_err = err_q;
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb_pipeline_stall_sequencer: two instances (LOAD_STALL=1/CNT_W=4, LOAD_STALL=3/CNT_W=16) on shared stimulus, scoreboard-checked
module tb_pipeline_stall_sequencer;
  localparam int MT = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pipeline_stall_sequencer_if #(.CNT_W(4)) b0();
  pipeline_stall_sequencer_if #(.CNT_W(16)) b1();
  pipeline_stall_sequencer #(.LOAD_STALL(1), .MEM_TIMEOUT(MT), .CNT_W(4)) dut0 (.clk(clk), .reset(rst), .bus(b0));
  pipeline_stall_sequencer #(.LOAD_STALL(3), .MEM_TIMEOUT(MT), .CNT_W(16)) dut1 (.clk(clk), .reset(rst), .bus(b1));
  typedef struct {
    bit pcw, ifw, ifl, idf, frz, err;
    int st, cnt, cyc;
  } exp_t;
  exp_t q0[$], q1[$];
  int n_checks = 0, n_fail = 0, cycle = 0;
  int ls[2] = '{1, 3};
  int cmax[2] = '{15, 65535};
  int m_st[2] = '{0, 0}, m_left[2] = '{0, 0}, m_wait[2] = '{0, 0}, m_ret[2] = '{0, 0}, m_cnt[2] = '{0, 0};
  bit m_err[2] = '{0, 0};
  function automatic void chk(string n, int k, int cy, logic [31:0] a, logic [31:0] x);
    n_checks++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", n, k, cy, a, x);
    end
  endfunction
  // Reference: mode 0 run,1 load bubbles,2 memory wait,3 halted,4 error; counters kept as plain ints
  task automatic model(input int k, input bit r, lu, br, jp, mrq, mrd, hl, output exp_t e);
    bit stall;
    int nst;
    stall = mrq && !mrd;
    e = '{pcw: 1, ifw: 1, ifl: 0, idf: 0, frz: 0, err: m_err[k], st: m_st[k], cnt: m_cnt[k], cyc: cycle};
    if (r) begin
      {e.pcw, e.ifw, e.ifl, e.idf} = 4'b0011;
      m_st[k] = 0; m_left[k] = 0; m_wait[k] = 0; m_ret[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      return;
    end
    nst = m_st[k];
    if ((m_st[k] == 0 || m_st[k] == 1) && stall) begin
      {e.pcw, e.ifw, e.frz} = 3'b001;
      m_ret[k] = m_st[k]; m_wait[k] = 1; nst = 2;
    end else if (m_st[k] == 0) begin
      if (br) {e.ifl, e.idf} = 2'b11;
      else if (lu) begin
        {e.pcw, e.ifw, e.idf} = 3'b001;
        if (ls[k] > 1) begin m_left[k] = ls[k] - 1; nst = 1; end
      end else if (jp) e.ifl = 1;
      else if (hl) begin {e.pcw, e.ifw, e.idf} = 3'b001; nst = 3; end
    end else if (m_st[k] == 1) begin
      {e.pcw, e.ifw, e.idf} = 3'b001;
      m_left[k]--;
      if (m_left[k] == 0) nst = 0;
    end else if (m_st[k] == 2) begin
      if (m_wait[k] == MT) begin {e.pcw, e.ifw, e.frz} = 3'b001; m_err[k] = 1; nst = 4; end
      else if (!mrd) begin {e.pcw, e.ifw, e.frz} = 3'b001; m_wait[k] = m_wait[k] < 255 ? m_wait[k] + 1 : 255; end
      else begin
        if (m_ret[k] == 1) {e.pcw, e.ifw, e.idf} = 3'b001;
        nst = m_ret[k];
      end
    end else if (m_st[k] == 3) {e.pcw, e.ifw, e.idf} = 3'b001;
    else {e.pcw, e.ifw, e.frz} = 3'b001;
    if (!e.pcw && m_st[k] <= 2 && m_cnt[k] < cmax[k]) m_cnt[k]++;
    m_st[k] = nst;
  endtask
  task automatic cyc(input bit r, lu, br, jp, mrq, mrd, hl);
    exp_t e;
    rst = r;
    {b0.load_use_hazard, b0.branch_taken, b0.jump, b0.mem_req, b0.mem_ready, b0.halt} = {lu, br, jp, mrq, mrd, hl};
    {b1.load_use_hazard, b1.branch_taken, b1.jump, b1.mem_req, b1.mem_ready, b1.halt} = {lu, br, jp, mrq, mrd, hl};
    model(0, r, lu, br, jp, mrq, mrd, hl, e);
    q0.push_back(e);
    model(1, r, lu, br, jp, mrq, mrd, hl, e);
    q1.push_back(e);
    @(posedge clk);
    #1 cycle++;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("PC_Write", 0, e.cyc, 32'(b0.PC_Write), 32'(e.pcw));
      chk("IFID_Write", 0, e.cyc, 32'(b0.IFID_Write), 32'(e.ifw));
      chk("IFID_flush", 0, e.cyc, 32'(b0.IFID_flush), 32'(e.ifl));
      chk("IDEX_flush", 0, e.cyc, 32'(b0.IDEX_flush), 32'(e.idf));
      chk("pipe_freeze", 0, e.cyc, 32'(b0.pipe_freeze), 32'(e.frz));
      chk("state", 0, e.cyc, 32'(b0.state), 32'(e.st));
      chk("stall_count", 0, e.cyc, 32'(b0.stall_count), 32'(e.cnt));
      chk("mem_timeout_err", 0, e.cyc, 32'(b0.mem_timeout_err), 32'(e.err));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("PC_Write", 1, e.cyc, 32'(b1.PC_Write), 32'(e.pcw));
      chk("IFID_Write", 1, e.cyc, 32'(b1.IFID_Write), 32'(e.ifw));
      chk("IFID_flush", 1, e.cyc, 32'(b1.IFID_flush), 32'(e.ifl));
      chk("IDEX_flush", 1, e.cyc, 32'(b1.IDEX_flush), 32'(e.idf));
      chk("pipe_freeze", 1, e.cyc, 32'(b1.pipe_freeze), 32'(e.frz));
      chk("state", 1, e.cyc, 32'(b1.state), 32'(e.st));
      chk("stall_count", 1, e.cyc, 32'(b1.stall_count), 32'(e.cnt));
      chk("mem_timeout_err", 1, e.cyc, 32'(b1.mem_timeout_err), 32'(e.err));
    end
  end
  initial begin
    int hold;
    bit mrq, mrd;
    {b0.load_use_hazard, b0.branch_taken, b0.jump, b0.mem_req, b0.mem_ready, b0.halt} = '0;
    {b1.load_use_hazard, b1.branch_taken, b1.jump, b1.mem_req, b1.mem_ready, b1.halt} = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 1, 1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0 && $urandom_range(0, 149) == 0) hold = $urandom_range(10, 20);
      mrq = hold > 0 || $urandom_range(0, 2) == 0;
      mrd = hold == 0 && $urandom_range(0, 2) != 0;
      if (hold > 0) hold--;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, mrq, mrd, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    n_checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
